// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the controller: FSM states,
// instruction field positions and the halt encoding.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [8:0] DEF_HALT_WORD = 9'h0FF;

  localparam int TYP_BIT = 8;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int RF_MSB  = 3;
  localparam int RF_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // jmp outranks br; a branch only redirects when its condition holds.
  function automatic logic take_target(input logic jmp_ctrl,
                                       input logic br_ctrl,
                                       input logic acc_true);
    return jmp_ctrl | (br_ctrl & acc_true);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection and sequential-increment overflow detect.
module fetch_unit_pc_next
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            jmp_ctrl,
  input  logic            br_ctrl,
  input  logic            acc_true,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_next,
  output logic            overflow
);

  // Overflow only arises from the sequential path; any redirect target is legal.
  always_comb begin
    pc_next  = pc;
    overflow = 1'b0;
    if (!stall) begin
      if (take_target(jmp_ctrl, br_ctrl, acc_true)) begin
        pc_next = target;
      end else if (pc == '1) begin
        overflow = 1'b1;
      end else begin
        pc_next = pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing: owns the PC, the IDLE/RUN/DONE machine
// and the RUN cycle counter, and slices ROM words into controller fields.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 9,
  parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD,
  parameter int                 CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               TYP,
  output logic [3:0]         OP,
  output logic [3:0]         rfield,
  output logic [7:0]         imm,
  input  logic               br_ctrl,
  input  logic               jmp_ctrl,
  input  logic               acc_true,
  input  logic [PC_W-1:0]    target,
  input  logic               stall,
  output logic               fetch_valid,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   cycle_count
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [PC_W-1:0]  pc_nxt;
  logic             pc_overflow;
  logic             is_halt;

  fetch_unit_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc       (pc_q),
    .stall    (stall),
    .jmp_ctrl (jmp_ctrl),
    .br_ctrl  (br_ctrl),
    .acc_true (acc_true),
    .target   (target),
    .pc_next  (pc_nxt),
    .overflow (pc_overflow)
  );

  assign is_halt = (rom_data == HALT_WORD);

  assign TYP    = rom_data[TYP_BIT];
  assign OP     = rom_data[OP_MSB:OP_LSB];
  assign rfield = rom_data[RF_MSB:RF_LSB];
  assign imm    = rom_data[IMM_MSB:IMM_LSB];

  assign rom_addr    = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign cycle_count = cnt_q;

  // A stalled halt waits; an unstalled halt beats any redirect from the controller.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = start_addr;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (!stall) begin
          if (is_halt) begin
            state_d = DONE;
          end else if (pc_overflow) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            pc_d = pc_nxt;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a ROM array stands in for program memory and
// the bench plays the controller by driving br_ctrl/jmp_ctrl directly.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;
  localparam logic [INSTR_W-1:0] HALT = 9'h0FF;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               start;
  logic [PC_W-1:0]    start_addr;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               TYP;
  logic [3:0]         OP;
  logic [3:0]         rfield;
  logic [7:0]         imm;
  logic               br_ctrl;
  logic               jmp_ctrl;
  logic               acc_true;
  logic [PC_W-1:0]    target;
  logic               stall;
  logic               fetch_valid;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   cycle_count;

  logic [INSTR_W-1:0] rom [0:(1<<PC_W)-1];

  int assertCount = 0;
  int failCount   = 0;

  fetch_unit dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .start_addr  (start_addr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .TYP         (TYP),
    .OP          (OP),
    .rfield      (rfield),
    .imm         (imm),
    .br_ctrl     (br_ctrl),
    .jmp_ctrl    (jmp_ctrl),
    .acc_true    (acc_true),
    .target      (target),
    .stall       (stall),
    .fetch_valid (fetch_valid),
    .done        (done),
    .err         (err),
    .cycle_count (cycle_count)
  );

  assign rom_data = rom[rom_addr];

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [PC_W-1:0] sa,
                               input logic j, input logic b, input logic a,
                               input logic [PC_W-1:0] tgt, input logic st);
    start      = s;
    start_addr = sa;
    jmp_ctrl   = j;
    br_ctrl    = b;
    acc_true   = a;
    target     = tgt;
    stall      = st;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<PC_W); i++) rom[i] = '0;
    rom[7]    = HALT;
    rom[40]   = 9'h1A5;
    rom[1023] = 9'h003;

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    RST_N = 1'b0;
    #2;
    checkOutput("reset_pc",    32'(rom_addr), 0);
    checkOutput("reset_done",  32'(done), 0);
    checkOutput("reset_err",   32'(err), 0);
    checkOutput("reset_valid", 32'(fetch_valid), 0);
    checkOutput("reset_cnt",   32'(cycle_count), 0);
    tick();
    RST_N = 1'b1;
    tick();
    checkOutput("idle_valid", 32'(fetch_valid), 0);

    // Straight-line run 3..7 with a stray start mid-run
    applyStimulus(1, 3, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 3, 0, 0, 0, 0, 0);
    checkOutput("run_pc3",    32'(rom_addr), 3);
    checkOutput("run_valid",  32'(fetch_valid), 1);
    checkOutput("run_cnt0",   32'(cycle_count), 0);
    for (int i = 4; i <= 7; i++) begin
      if (i == 5) applyStimulus(1, 100, 0, 0, 0, 0, 0);
      else        applyStimulus(0, 100, 0, 0, 0, 0, 0);
      tick();
      checkOutput("run_seq_pc", 32'(rom_addr), 32'(i));
    end
    checkOutput("pre_halt_done", 32'(done), 0);
    tick();
    checkOutput("halt_done",  32'(done), 1);
    checkOutput("halt_cnt",   32'(cycle_count), 5);
    checkOutput("halt_pc",    32'(rom_addr), 7);
    checkOutput("halt_valid", 32'(fetch_valid), 0);
    tick();
    checkOutput("done_hold_pc",  32'(rom_addr), 7);
    checkOutput("done_hold_cnt", 32'(cycle_count), 5);

    // Restart from DONE at 10, then branches and jumps
    applyStimulus(1, 10, 0, 0, 0, 0, 0);
    tick();
    checkOutput("restart_pc",   32'(rom_addr), 10);
    checkOutput("restart_cnt",  32'(cycle_count), 0);
    checkOutput("restart_done", 32'(done), 0);
    applyStimulus(0, 10, 0, 1, 1, 40, 0);
    tick();
    checkOutput("btr_taken_pc", 32'(rom_addr), 40);
    checkOutput("btr_cnt",      32'(cycle_count), 1);
    checkOutput("field_typ",    32'(TYP), 1);
    checkOutput("field_op",     32'(OP), 32'hA);
    checkOutput("field_rf",     32'(rfield), 5);
    checkOutput("field_imm",    32'(imm), 32'hA5);
    applyStimulus(0, 0, 1, 0, 0, 10, 0);
    tick();
    checkOutput("jmp_back_pc", 32'(rom_addr), 10);
    applyStimulus(0, 0, 0, 1, 0, 40, 0);
    tick();
    checkOutput("btr_not_taken_pc", 32'(rom_addr), 11);
    applyStimulus(0, 0, 1, 1, 0, 20, 0);
    tick();
    checkOutput("jmp_over_br_pc", 32'(rom_addr), 20);

    // JMP at 20 held by two stall cycles
    applyStimulus(0, 0, 1, 0, 0, 2, 1);
    tick();
    checkOutput("stall1_pc",  32'(rom_addr), 20);
    checkOutput("stall1_cnt", 32'(cycle_count), 5);
    tick();
    checkOutput("stall2_pc",  32'(rom_addr), 20);
    checkOutput("stall2_cnt", 32'(cycle_count), 6);
    applyStimulus(0, 0, 1, 0, 0, 2, 0);
    tick();
    checkOutput("jmp_after_stall_pc", 32'(rom_addr), 2);
    checkOutput("jmp_after_stall_cnt", 32'(cycle_count), 7);

    // Walk to the halt at 7, stall on it, then halt beats a jmp
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();
    checkOutput("walk_pc", 32'(rom_addr), 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("halt_stall_done",  32'(done), 0);
    checkOutput("halt_stall_valid", 32'(fetch_valid), 1);
    checkOutput("halt_stall_pc",    32'(rom_addr), 7);
    applyStimulus(0, 0, 1, 0, 0, 50, 0);
    tick();
    checkOutput("halt_over_jmp_done", 32'(done), 1);
    checkOutput("halt_over_jmp_pc",   32'(rom_addr), 7);
    checkOutput("halt_over_jmp_cnt",  32'(cycle_count), 14);

    // PC overflow from 1023, then a restart clears err
    applyStimulus(1, 1023, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ovf_start_pc",  32'(rom_addr), 1023);
    checkOutput("ovf_start_err", 32'(err), 0);
    tick();
    checkOutput("ovf_err",  32'(err), 1);
    checkOutput("ovf_done", 32'(done), 1);
    checkOutput("ovf_pc",   32'(rom_addr), 1023);
    checkOutput("ovf_cnt",  32'(cycle_count), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("clr_err",   32'(err), 0);
    checkOutput("clr_pc",    32'(rom_addr), 0);
    checkOutput("clr_valid", 32'(fetch_valid), 1);
    repeat (5) tick();
    checkOutput("pre_rst_pc",  32'(rom_addr), 5);
    checkOutput("pre_rst_cnt", 32'(cycle_count), 5);

    // Asynchronous reset between edges
    #3;
    RST_N = 1'b0;
    #1;
    checkOutput("async_rst_pc",    32'(rom_addr), 0);
    checkOutput("async_rst_done",  32'(done), 0);
    checkOutput("async_rst_valid", 32'(fetch_valid), 0);
    checkOutput("async_rst_cnt",   32'(cycle_count), 0);
    tick();
    checkOutput("rst_hold_pc", 32'(rom_addr), 0);
    RST_N = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and sequencing block. It is the producer side of the controller's interface: it drives TYP/OP and operand fields to the controller, and it consumes br_ctrl/jmp_ctrl back to steer the program counter. It owns the PC, the run/halt state machine and the cycle counter, and sits between the start/done testbench handshake and the instruction ROM.

Parameters:
PC_W, 10, program counter / ROM address width
INSTR_W, 9, instruction width (bit 8 = TYP, bits 7:4 = OP, bits 3:0 = reg field; M-type imm = bits 7:0)
HALT_WORD, 9'h0FF, O-type encoding that terminates the program
CNT_W, 16, cycle counter width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution
start_addr  in  PC_W  first PC after start
rom_addr  out  PC_W  ROM address (= pc)
rom_data  in  INSTR_W  instruction at rom_addr, combinational read
TYP  out  1  rom_data[8] to controller
OP  out  4  rom_data[7:4] to controller
rfield  out  4  rom_data[3:0]
imm  out  8  rom_data[7:0]
br_ctrl  in  1  from controller: current instr is BTR
jmp_ctrl  in  1  from controller: current instr is JMP
acc_true  in  1  accumulator bit 0, branch condition
target  in  PC_W  branch/jump destination (register contents from datapath)
stall  in  1  hold PC this cycle
fetch_valid  out  1  high in RUN; datapath commits only when fetch_valid=1 and stall=0
done  out  1  high in DONE
err  out  1  sticky; PC overflowed
cycle_count  out  CNT_W  RUN cycles since last start

Behaviour:
- Reset (RST_N=0, async): state=IDLE, pc=0, done=0, err=0, cycle_count=0, fetch_valid=0. Reset mid-RUN aborts immediately with no further PC update.
- Field outputs are combinational slices of rom_data in every state. In IDLE/DONE the controller's outputs are ignored.
- States:
  - IDLE. On start: pc<=start_addr, cycle_count<=0, err<=0, next state RUN.
  - RUN. Each cycle: cycle_count++ (saturates at all-ones). If stall=1, pc holds. Otherwise:
    - rom_data==HALT_WORD: state<=DONE, pc holds. Halt has priority over br/jmp.
    - else if jmp_ctrl: pc<=target.
    - else if br_ctrl && acc_true: pc<=target.
    - else if br_ctrl && !acc_true: pc<=pc+1.
    - else pc<=pc+1.
  - DONE. done=1, pc and cycle_count hold. On start: behaves as the IDLE start (done falls next cycle).
- Start pulses during RUN are ignored.
- Latency: one cycle from a ROM word being presented to the PC update. Branches have no delay slot; the target instruction is presented the next cycle.
- Overflow: sequential increment from pc=2^PC_W-1 sets err=1, state<=DONE, pc holds. A jmp/branch target of any value is legal.
- If jmp_ctrl and br_ctrl are both high (illegal from the controller), jmp wins.
- Halt while stall=1 is deferred until stall=0.

Decomposition:
- definitions package:
  - fetch_state_t enum {IDLE, RUN, DONE}
  - HALT_WORD constant
  - TYP_BIT and OP field position constants, shared with controller
- Sub-module pc_next: combinational next-PC and overflow computation from pc, stall, jmp_ctrl, br_ctrl, acc_true and target. The FSM and counter stay in fetch_unit.

Test Plan:
- Reset mid-RUN (pc=5): assert RST_N=0 asynchronously -> pc=0, state IDLE, done=0 before the next edge; cycle_count=0.
- start with start_addr=3, ROM 3..6 plain ADDs, 7=HALT_WORD -> rom_addr 3,4,5,6,7, then done=1 from the next cycle; cycle_count=5; pc stays 7.
- At pc=10, BTR with acc_true=1, target=40 -> pc=40 next cycle. Repeat with acc_true=0 -> pc=11.
- JMP at pc=20, target=2, with stall=1 for 2 cycles -> pc holds 20 for 2 cycles, then 2; cycle_count increments during the stall.
- start_addr=1023 with a non-halt, non-branch instr -> err=1, done=1, pc=1023. A following start clears err.
- start asserted during RUN -> ignored, PC sequence unchanged. start in DONE -> restarts at start_addr with cycle_count=0.
